// File: rtl/fc_stats_pkg.sv
// Shared types for the frame statistics block: snapshot record, handshake states, min-length init.
package fc_stats_pkg;

   localparam int STATS_CNT_W = 32;
   localparam int STATS_LEN_W = 16;

   typedef struct packed {
      logic [STATS_CNT_W-1:0] good_frames;
      logic [STATS_CNT_W-1:0] bad_frames;
      logic [STATS_CNT_W-1:0] viol_events;
      logic [STATS_CNT_W-1:0] bb_events;
      logic [STATS_CNT_W-1:0] word_cnt;
      logic [STATS_LEN_W-1:0] len_min;
      logic [STATS_LEN_W-1:0] len_max;
   } stats_snap_t;

   typedef enum logic {IDLE, WAIT} snap_st_e;

   localparam logic [STATS_LEN_W-1:0] LEN_INIT_MIN = '1;

endpackage

// File: rtl/frame_err_stats_if.sv
// Framing strobes from the link engine plus the snapshot request/ack and snapshot counter bus.
interface frame_err_stats_if #(
   parameter int CNT_W = 32,
   parameter int LEN_W = 16
);
   logic             sop;
   logic             eop;
   logic             valid;
   logic             active;
   logic             violation;
   logic             eop_bb;
   logic             snap_req;
   logic             snap_ack;
   logic [CNT_W-1:0] good_frames;
   logic [CNT_W-1:0] bad_frames;
   logic [CNT_W-1:0] viol_events;
   logic [CNT_W-1:0] bb_events;
   logic [CNT_W-1:0] word_cnt;
   logic [LEN_W-1:0] len_min;
   logic [LEN_W-1:0] len_max;

   modport master (
      output sop, eop, valid, active, violation, eop_bb, snap_req,
      input  snap_ack, good_frames, bad_frames, viol_events, bb_events, word_cnt, len_min, len_max
   );

   modport slave (
      input  sop, eop, valid, active, violation, eop_bb, snap_req,
      output snap_ack, good_frames, bad_frames, viol_events, bb_events, word_cnt, len_min, len_max
   );
endinterface

// File: rtl/frame_err_stats_sat_inc_clr.sv
// sat_inc_clr: saturating event counter with synchronous clear; clear and increment together give 1.
// Latency: count visible 1 cycle after inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_inc_clr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= inc ? W'(1) : '0;
      end else if (inc && !(&q)) begin
         q <= q + 1'b1;
      end
   end
endmodule

// File: rtl/frame_err_stats.sv
// frame_err_stats: per-channel frame/violation/word counters with atomic snapshot; length stats under FRAME_ERR_STATS_LEN_EN.
// Latency: counters update 1 cycle after the input cycle; snap_ack and snapshot 1 cycle after snap_req seen in IDLE.
// Backpressure: none; every cycle is sampled, requester holds snap_req until snap_ack.
module frame_err_stats
   import fc_stats_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int LEN_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   frame_err_stats_if.slave bus
);
   localparam int NCNT = 5;

   logic             sop_v, eop_v;
   logic             in_frm, frm_bad, viol_d;
   logic             good_inc, bad_inc, copy, ack_q;
   logic [NCNT-1:0]  inc_vec;
   logic [CNT_W-1:0] run_cnt  [NCNT];
   logic [CNT_W-1:0] snap_cnt [NCNT];
   snap_st_e         st_q, st_d;

   assign sop_v = bus.sop & bus.valid;
   assign eop_v = bus.eop & bus.valid;

   // A single-word frame (sop and eop together) is always counted bad and never measured.
   assign bad_inc  = (sop_v & eop_v) | (eop_v & in_frm & (frm_bad | bus.violation));
   assign good_inc = eop_v & in_frm & ~sop_v & ~frm_bad & ~bus.violation;
   assign inc_vec  = {bus.valid & bus.active, bus.eop_bb, bus.violation & ~viol_d, bad_inc, good_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_frm  <= 1'b0;
         frm_bad <= 1'b0;
         viol_d  <= 1'b0;
      end else begin
         viol_d <= bus.violation;
         if (sop_v) begin
            in_frm  <= ~eop_v;
            frm_bad <= bus.violation;
         end else begin
            if (eop_v) in_frm <= 1'b0;
            if (in_frm && bus.violation) frm_bad <= 1'b1;
         end
      end
   end

   always_comb begin
      st_d = st_q;
      copy = 1'b0;
      case (st_q)
         IDLE: if (bus.snap_req) begin
            copy = 1'b1;
            st_d = WAIT;
         end
         WAIT: if (!bus.snap_req) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= IDLE;
         ack_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         ack_q <= copy;
      end
   end

   // Running counters clear on copy; events of the copy cycle land in the new interval.
   for (genvar g = 0; g < NCNT; g++) begin : g_cnt
      sat_inc_clr #(.W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc_vec[g]),
         .clr   (copy),
         .q     (run_cnt[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCNT; i++) snap_cnt[i] <= '0;
      end else if (copy) begin
         for (int i = 0; i < NCNT; i++) snap_cnt[i] <= run_cnt[i];
      end
   end

   assign bus.snap_ack    = ack_q;
   assign bus.good_frames = snap_cnt[0];
   assign bus.bad_frames  = snap_cnt[1];
   assign bus.viol_events = snap_cnt[2];
   assign bus.bb_events   = snap_cnt[3];
   assign bus.word_cnt    = snap_cnt[4];

`ifdef FRAME_ERR_STATS_LEN_EN
   logic [LEN_W-1:0] len_q, len_cls, min_q, max_q, snap_min, snap_max;

   // Length of the closing frame including its EOP word.
   assign len_cls = (&len_q) ? len_q : len_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         min_q    <= '1;
         max_q    <= '0;
         snap_min <= '0;
         snap_max <= '0;
      end else begin
         if (sop_v) len_q <= LEN_W'(1);
         else if (bus.valid && in_frm && !(&len_q)) len_q <= len_q + 1'b1;

         if (copy) begin
            min_q    <= good_inc ? len_cls : '1;
            max_q    <= good_inc ? len_cls : '0;
            snap_min <= (run_cnt[0] == '0) ? '0 : min_q;
            snap_max <= max_q;
         end else if (good_inc) begin
            if (len_cls < min_q) min_q <= len_cls;
            if (len_cls > max_q) max_q <= len_cls;
         end
      end
   end

   assign bus.len_min = snap_min;
   assign bus.len_max = snap_max;
`else
   assign bus.len_min = {LEN_W{1'b0}};
   assign bus.len_max = {LEN_W{1'b0}};
`endif

endmodule

// File: tb/tb_frame_err_stats.sv
// Scoreboard bench for frame_err_stats: spec-level model pushes expected snapshots, a monitor checks each snap_ack.
module tb_frame_err_stats;
   import fc_stats_pkg::*;

   localparam longint CMAX = 64'hFFFF_FFFF;
   localparam int     LMAX = 65535;
`ifdef FRAME_ERR_STATS_LEN_EN
   localparam bit LEN_ON = 1'b1;
`else
   localparam bit LEN_ON = 1'b0;
`endif

   logic clk, rst_n;
   logic s_inc, s_clr;
   logic [3:0] s_q;

   frame_err_stats_if #(.CNT_W(32), .LEN_W(16)) bus ();

   frame_err_stats #(.CNT_W(32), .LEN_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sat_inc_clr #(.W(4)) u_sat4 (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (s_inc),
      .clr   (s_clr),
      .q     (s_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int push_cnt = 0;
   int ack_cnt = 0;
   stats_snap_t exp_q[$];
   stats_snap_t last_got;

   // Reference model state: interval totals plus the current frame as seen by the spec.
   longint m_good, m_bad, m_ve, m_be, m_wc;
   int     m_mn, m_mx, m_len;
   bit     m_in, m_fbad, m_vprev, m_wait;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint sat(input longint x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   task automatic m_clear();
      m_good = 0; m_bad = 0; m_ve = 0; m_be = 0; m_wc = 0;
      m_mn = LEN_INIT_MIN; m_mx = 0;
   endtask

   task automatic m_reset();
      m_clear();
      m_len = 0; m_in = 0; m_fbad = 0; m_vprev = 0; m_wait = 0;
   endtask

   task automatic push_snap();
      stats_snap_t e;
      e.good_frames = m_good[31:0];
      e.bad_frames  = m_bad[31:0];
      e.viol_events = m_ve[31:0];
      e.bb_events   = m_be[31:0];
      e.word_cnt    = m_wc[31:0];
      e.len_min     = (LEN_ON && m_good != 0) ? 16'(m_mn) : 16'd0;
      e.len_max     = LEN_ON ? 16'(m_mx) : 16'd0;
      exp_q.push_back(e);
      push_cnt++;
      m_clear();
   endtask

   // Drive one input cycle, account for it in the model, advance to the next falling edge.
   task automatic step(input bit s, input bit e, input bit v, input bit a,
                       input bit vi, input bit bb, input bit rq);
      bit sv, ev;
      int l;
      bus.sop = s; bus.eop = e; bus.valid = v; bus.active = a;
      bus.violation = vi; bus.eop_bb = bb; bus.snap_req = rq;
      if (rq && !m_wait) begin
         push_snap();
         m_wait = 1;
      end else if (!rq) begin
         m_wait = 0;
      end
      sv = s & v;
      ev = e & v;
      if (sv && ev) begin
         m_bad = sat(m_bad + 1);
      end else if (ev && m_in) begin
         if (m_fbad || vi) begin
            m_bad = sat(m_bad + 1);
         end else begin
            m_good = sat(m_good + 1);
            l = (m_len + 1 > LMAX) ? LMAX : m_len + 1;
            if (l < m_mn) m_mn = l;
            if (l > m_mx) m_mx = l;
         end
      end
      if (vi && !m_vprev) m_ve = sat(m_ve + 1);
      if (bb) m_be = sat(m_be + 1);
      if (v && a) m_wc = sat(m_wc + 1);
      if (sv) begin
         m_len = 1;
         m_fbad = vi;
      end else begin
         if (m_in && v && m_len < LMAX) m_len++;
         if (m_in && vi) m_fbad = 1;
      end
      m_in = sv ? !ev : (ev ? 1'b0 : m_in);
      m_vprev = vi;
      @(negedge clk);
   endtask

   task automatic snap();
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.snap_ack) begin
         stats_snap_t e, g;
         ack_cnt++;
         g.good_frames = bus.good_frames;
         g.bad_frames  = bus.bad_frames;
         g.viol_events = bus.viol_events;
         g.bb_events   = bus.bb_events;
         g.word_cnt    = bus.word_cnt;
         g.len_min     = bus.len_min;
         g.len_max     = bus.len_max;
         last_got = g;
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("good_frames", g.good_frames, e.good_frames);
            chk("bad_frames",  g.bad_frames,  e.bad_frames);
            chk("viol_events", g.viol_events, e.viol_events);
            chk("bb_events",   g.bb_events,   e.bb_events);
            chk("word_cnt",    g.word_cnt,    e.word_cnt);
            chk("len_min",     g.len_min,     e.len_min);
            chk("len_max",     g.len_max,     e.len_max);
         end
      end
   end

   initial begin
      int ph;
      bit vi;
      rst_n = 1'b0;
      s_inc = 1'b0; s_clr = 1'b0;
      bus.sop = 0; bus.eop = 0; bus.valid = 0; bus.active = 0;
      bus.violation = 0; bus.eop_bb = 0; bus.snap_req = 0;
      m_reset();
      #3;
      chk("rst_ack",  bus.snap_ack, 0);
      chk("rst_good", bus.good_frames, 0);
      chk("rst_word", bus.word_cnt, 0);
      chk("rst_lmin", bus.len_min, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Clean 5-word frame.
      step(1, 0, 1, 1, 0, 0, 0);
      repeat (3) step(0, 0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0, 0);
      snap();
      chk("t1_good", last_got.good_frames, 1);
      chk("t1_bad",  last_got.bad_frames, 0);
      chk("t1_word", last_got.word_cnt, 5);
      chk("t1_lmin", last_got.len_min, LEN_ON ? 5 : 0);
      chk("t1_lmax", last_got.len_max, LEN_ON ? 5 : 0);

      // Violation held two cycles mid-frame.
      step(1, 0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 1, 0, 0);
      step(0, 0, 1, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0, 0);
      snap();
      chk("t2_bad",  last_got.bad_frames, 1);
      chk("t2_viol", last_got.viol_events, 1);
      chk("t2_good", last_got.good_frames, 0);
      chk("t2_lmin", last_got.len_min, 0);

      // Single-word frame, then a bare EOP.
      step(1, 1, 1, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0, 1, 0);
      snap();
      chk("t3_bad", last_got.bad_frames, 1);
      chk("t3_bb",  last_got.bb_events, 1);
      chk("t3_good", last_got.good_frames, 0);

      // Request lands on the closing EOP of a good frame.
      step(1, 0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t4a_good", last_got.good_frames, 0);
      chk("t4a_word", last_got.word_cnt, 2);
      snap();
      chk("t4b_good", last_got.good_frames, 1);
      chk("t4b_word", last_got.word_cnt, 1);
      chk("t4b_lmax", last_got.len_max, LEN_ON ? 3 : 0);

      // Reset while waiting for snap_req to drop.
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      bus.snap_req = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_ack",  bus.snap_ack, 0);
      chk("t5_good", bus.good_frames, 0);
      chk("t5_word", bus.word_cnt, 0);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t5_acks", ack_cnt, 7);

      // Randomized traffic with spaced snapshot requests.
      ph = 0;
      vi = 0;
      for (int i = 0; i < 3000; i++) begin
         if (ph == 0 && $urandom_range(0, 29) == 0) ph = 3;
         if ($urandom_range(0, 11) == 0) vi = ~vi;
         step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) != 0, vi, $urandom_range(0, 9) == 0, ph >= 2);
         if (ph > 0) ph--;
      end
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      snap();
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      chk("queue_empty", exp_q.size(), 0);
      chk("ack_count", ack_cnt, push_cnt);

      // 4-bit saturating counter: preload to 14, then 3 more events.
      s_clr = 1; s_inc = 0;
      @(negedge clk);
      s_clr = 0; s_inc = 1;
      repeat (14) @(negedge clk);
      chk("sat4_pre", s_q, 14);
      repeat (3) @(negedge clk);
      chk("sat4_hold", s_q, 15);
      s_clr = 1; s_inc = 1;
      @(negedge clk);
      chk("sat4_clrinc", s_q, 1);
      s_clr = 1; s_inc = 0;
      @(negedge clk);
      chk("sat4_clr", s_q, 0);
      s_clr = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
